// File: rtl/fifo_serial_tx.sv
// Serial transmitter fed by a latch FIFO: one-word holding register in front of
// a START/DATA/PARITY/STOP shift engine, LSB first, line idles high.
module fifo_serial_tx #(
  parameter int WIDTH        = 6,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_write,
  output logic             fifo_pop,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [2:0]       state_dbg
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   hold, hold_n;
  logic               hold_valid, hold_valid_n;
  logic [WIDTH-1:0]   shifter, shifter_n;
  logic [7:0]         timer, timer_n;
  logic [IDX_W-1:0]   bit_idx, bit_idx_n;
  logic               par_bit, par_bit_n;
  logic               tx_n;
  logic               load;

  // Handshake: fifo_write is valid, fifo_pop is ready; a word transfers on a
  // rising edge where both are high. Ready depends only on the holding register.
  assign fifo_pop   = reset_n && !hold_valid;
  assign busy       = hold_valid || (state != IDLE);
  assign frame_done = (state == STOP) && (timer == 8'd0);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      shifter    <= '0;
      timer      <= 8'd0;
      bit_idx    <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state      <= state_n;
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
      shifter    <= shifter_n;
      timer      <= timer_n;
      bit_idx    <= bit_idx_n;
      par_bit    <= par_bit_n;
      tx         <= tx_n;
    end
  end

  always_comb begin
    state_n      = state;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    shifter_n    = shifter;
    timer_n      = timer;
    bit_idx_n    = bit_idx;
    par_bit_n    = par_bit;
    tx_n         = tx;
    load         = 1'b0;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (hold_valid) load = 1'b1;
      end
      START: begin
        if (timer == 8'd0) begin
          state_n   = DATA;
          timer_n   = BIT_LAST;
          bit_idx_n = '0;
          tx_n      = shifter[0];
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      DATA: begin
        if (timer == 8'd0) begin
          timer_n = BIT_LAST;
          if (bit_idx == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            shifter_n = shifter >> 1;
            bit_idx_n = bit_idx + 1'b1;
            tx_n      = shifter_n[0];
          end
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      PARITY: begin
        if (timer == 8'd0) begin
          state_n = STOP;
          timer_n = BIT_LAST;
          tx_n    = 1'b1;
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      STOP: begin
        if (timer == 8'd0) begin
          // A waiting word starts immediately so frames stay contiguous.
          if (hold_valid) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    if (load) begin
      shifter_n    = hold;
      par_bit_n    = (^hold) ^ (PARITY_ODD != 0);
      hold_valid_n = 1'b0;
      state_n      = START;
      timer_n      = BIT_LAST;
      bit_idx_n    = '0;
      tx_n         = 1'b0;
    end

    // Capture needs hold_valid=0, load needs hold_valid=1: never both.
    if (fifo_pop && fifo_write) begin
      hold_n       = fifo_data;
      hold_valid_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: a latch-FIFO model drives four instances
// (default, even parity, odd parity, one clock per bit); tx is checked cycle by cycle.
module tb_fifo_serial_tx;

  logic       clk;
  logic       reset_n;
  logic [5:0] fifo_data;
  logic       fifo_write;

  logic       pop_m, tx_m, busy_m, fd_m;
  logic       pop_e, tx_e, busy_e, fd_e;
  logic       pop_o, tx_o, busy_o, fd_o;
  logic       pop_f, tx_f, busy_f, fd_f;
  logic [2:0] st_m, st_e, st_o, st_f;

  int         sel;
  logic       pop_s, tx_s, busy_s, fd_s;
  logic [2:0] st_s;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] fifo_q[$];
  logic       pending;

  fifo_serial_tx dut (
    .clk(clk), .reset_n(reset_n), .fifo_data(fifo_data), .fifo_write(fifo_write),
    .fifo_pop(pop_m), .tx(tx_m), .busy(busy_m), .frame_done(fd_m), .state_dbg(st_m)
  );

  fifo_serial_tx #(.PARITY_EN(1), .PARITY_ODD(0)) dut_even (
    .clk(clk), .reset_n(reset_n), .fifo_data(fifo_data), .fifo_write(fifo_write),
    .fifo_pop(pop_e), .tx(tx_e), .busy(busy_e), .frame_done(fd_e), .state_dbg(st_e)
  );

  fifo_serial_tx #(.PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .reset_n(reset_n), .fifo_data(fifo_data), .fifo_write(fifo_write),
    .fifo_pop(pop_o), .tx(tx_o), .busy(busy_o), .frame_done(fd_o), .state_dbg(st_o)
  );

  fifo_serial_tx #(.CLKS_PER_BIT(1)) dut_fast (
    .clk(clk), .reset_n(reset_n), .fifo_data(fifo_data), .fifo_write(fifo_write),
    .fifo_pop(pop_f), .tx(tx_f), .busy(busy_f), .frame_done(fd_f), .state_dbg(st_f)
  );

  always_comb begin
    case (sel)
      1:       {pop_s, tx_s, busy_s, fd_s, st_s} = {pop_e, tx_e, busy_e, fd_e, st_e};
      2:       {pop_s, tx_s, busy_s, fd_s, st_s} = {pop_o, tx_o, busy_o, fd_o, st_o};
      3:       {pop_s, tx_s, busy_s, fd_s, st_s} = {pop_f, tx_f, busy_f, fd_f, st_f};
      default: {pop_s, tx_s, busy_s, fd_s, st_s} = {pop_m, tx_m, busy_m, fd_m, st_m};
    endcase
  end

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: sample point is the falling edge, then the FIFO model updates.
  task automatic tick();
    @(negedge clk);
    if (pending) fifo_q.delete(0);
    if (fifo_q.size() > 0) begin
      fifo_write = 1'b1;
      fifo_data  = fifo_q[0];
    end else begin
      fifo_write = 1'b0;
      fifo_data  = '0;
    end
    pending = fifo_write && pop_m;
  endtask

  task automatic do_reset(input string tag);
    reset_n    = 1'b0;
    fifo_write = 1'b0;
    fifo_data  = '0;
    pending    = 1'b0;
    fifo_q.delete();
    repeat (2) @(negedge clk);
    sel = 0;
    #1;
    check({tag, "_rst_tx"},    32'(tx_m),   32'd1);
    check({tag, "_rst_busy"},  32'(busy_m), 32'd0);
    check({tag, "_rst_pop"},   32'(pop_m),  32'd0);
    check({tag, "_rst_done"},  32'(fd_m),   32'd0);
    check({tag, "_rst_state"}, 32'(st_m),   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check({tag, "_rel_pop"}, 32'(pop_m), 32'd1);
  endtask

  // bits holds the line levels in send order, first level in the MSB position.
  task automatic expect_frame(input string tag, input int sel_i, input logic [15:0] bits,
                              input int nbits, input int cpb, input int pop_hi);
    int n;
    sel = sel_i;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb; c++) begin
        tick();
        n = b * cpb + c;
        check({tag, "_tx"},   32'(tx_s),   32'(bits[nbits-1-b]));
        check({tag, "_done"}, 32'(fd_s),   32'(n == nbits * cpb - 1));
        check({tag, "_busy"}, 32'(busy_s), 32'd1);
        if (sel_i == 0) check({tag, "_pop"}, 32'(pop_s), 32'(n < pop_hi));
      end
    end
  endtask

  task automatic expect_idle(input string tag, input int sel_i);
    sel = sel_i;
    tick();
    check({tag, "_idle_tx"},   32'(tx_s),   32'd1);
    check({tag, "_idle_busy"}, 32'(busy_s), 32'd0);
    check({tag, "_idle_done"}, 32'(fd_s),   32'd0);
    check({tag, "_idle_pop"},  32'(pop_s),  32'd1);
  endtask

  // Two cycles from presenting a word: capture edge, then the load edge.
  task automatic lead_in(input string tag, input int sel_i);
    sel = sel_i;
    tick();
    check({tag, "_pre_tx"},   32'(tx_s),   32'd1);
    check({tag, "_pre_busy"}, 32'(busy_s), 32'd0);
    tick();
    check({tag, "_held_tx"},   32'(tx_s),   32'd1);
    check({tag, "_held_busy"}, 32'(busy_s), 32'd1);
    check({tag, "_held_pop"},  32'(pop_s),  32'd0);
  endtask

  initial begin
    sel     = 0;
    pending = 1'b0;

    // Single word 0x2D: 0 | 1 0 1 1 0 1 | 1
    do_reset("single");
    fifo_q.push_back(6'h2D);
    lead_in("single", 0);
    expect_frame("single", 0, 16'b01011011, 8, 4, 32);
    expect_idle("single", 0);

    // Parity on 0x2D (four ones): even -> 0, odd -> 1, 36-cycle frames
    do_reset("par_even");
    fifo_q.push_back(6'h2D);
    lead_in("par_even", 1);
    expect_frame("par_even", 1, 16'b010110101, 9, 4, 36);
    expect_idle("par_even", 1);

    do_reset("par_odd");
    fifo_q.push_back(6'h2D);
    lead_in("par_odd", 2);
    expect_frame("par_odd", 2, 16'b010110111, 9, 4, 36);
    expect_idle("par_odd", 2);

    // One clock per bit, 0x2A: 0 0 1 0 1 0 1 1
    do_reset("cpb1");
    fifo_q.push_back(6'h2A);
    lead_in("cpb1", 3);
    expect_frame("cpb1", 3, 16'b00101011, 8, 1, 8);
    expect_idle("cpb1", 3);

    // Back-to-back with backpressure: the second word waits while hold is full
    do_reset("b2b");
    fifo_q.push_back(6'h01);
    fifo_q.push_back(6'h3F);
    fifo_q.push_back(6'h15);
    lead_in("b2b", 0);
    check("b2b_bp_write", 32'(fifo_write), 32'd1);
    expect_frame("b2b_w0", 0, 16'b01000001, 8, 4, 1);
    expect_frame("b2b_w1", 0, 16'b01111111, 8, 4, 1);
    expect_frame("b2b_w2", 0, 16'b01010101, 8, 4, 32);
    expect_idle("b2b", 0);

    // Reset during DATA bit 3 of 0x07 (bit 3 drives 0)
    do_reset("midrst");
    fifo_q.push_back(6'h07);
    lead_in("midrst", 0);
    for (int i = 0; i < 18; i++) tick();
    check("midrst_bit3_tx",   32'(tx_m),   32'd0);
    check("midrst_bit3_busy", 32'(busy_m), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_abort_tx",   32'(tx_m),   32'd1);
    check("midrst_abort_busy", 32'(busy_m), 32'd0);
    check("midrst_abort_pop",  32'(pop_m),  32'd0);
    check("midrst_abort_done", 32'(fd_m),   32'd0);
    fifo_q.delete();
    pending    = 1'b0;
    fifo_write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("midrst_rel_pop", 32'(pop_m), 32'd1);
    fifo_q.push_back(6'h2D);
    lead_in("midrst_next", 0);
    expect_frame("midrst_next", 0, 16'b01011011, 8, 4, 32);
    expect_idle("midrst_next", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 6, word width, matching the upstream latch FIFO.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit, legal range 1..255.
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 = append a parity bit after the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port fifo_data  input  WIDTH  word presented by the FIFO.
REQ-008 SHALL have port fifo_write  input  1  FIFO transfers fifo_data this cycle.
REQ-009 SHALL have port fifo_pop  output  1  block can accept a word this cycle (drives the FIFO pop).
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  holding register full or frame in progress.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of each stop bit.

Function
REQ-013 SHALL contain a one-word holding register (hold, hold_valid) and a shift engine with states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL drive fifo_pop = reset_n && !hold_valid, with no combinational dependence on fifo_write or fifo_data.
REQ-015 SHALL capture fifo_data into hold and set hold_valid on a rising edge where fifo_pop && fifo_write; fifo_write while fifo_pop=0 SHALL be ignored.
REQ-016 SHALL, on an edge in IDLE with hold_valid=1, load the shifter from hold, clear hold_valid, enter START; a word captured at edge E therefore starts at edge E+1 (tx low visible after E+1).
REQ-017 SHALL register tx: START drives 0, DATA drives shifter bit 0 (LSB first), PARITY drives parity, STOP and IDLE drive 1.
REQ-018 SHALL hold each of START, each DATA bit, PARITY and STOP for exactly CLKS_PER_BIT cycles via a bit-timer counter reloaded on every bit boundary.
REQ-019 SHALL sequence START -> DATA (WIDTH bits, counted by a bit index of ceil(log2(WIDTH+1)) bits) -> PARITY (only if PARITY_EN) -> STOP.
REQ-020 SHALL compute parity as XOR of the WIDTH loaded bits, inverted when PARITY_ODD=1.
REQ-021 SHALL pulse frame_done high for the last cycle of STOP only.
REQ-022 SHALL, at the end of STOP with hold_valid=1, load hold and go directly to START (no idle cycle); otherwise go to IDLE.
REQ-023 SHALL allow a capture into hold on the same edge that hold is loaded into the shifter only if hold_valid was 0 before that edge (fifo_pop is low whenever hold_valid=1, so no overwrite is possible).
REQ-024 SHALL keep busy = hold_valid || (state != IDLE).
REQ-025 SHALL make total frame length (2 + WIDTH + PARITY_EN) * CLKS_PER_BIT cycles.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force state=IDLE, hold_valid=0, counters=0, tx=1, frame_done=0, busy=0, fifo_pop=0.
REQ-027 SHALL abort any frame in progress on reset assertion mid-frame, with tx returning to 1 immediately and the word discarded.
REQ-028 SHALL assert fifo_pop in the first cycle after reset_n deasserts.

Verification
REQ-029 SHALL cover single word: WIDTH=6, CLKS_PER_BIT=4, fifo_data=0x2D with fifo_write for 1 cycle -> tx after start = 0,1,0,1,1,0,1,1 each 4 cycles, frame_done once at cycle 32, busy low after.
REQ-030 SHALL cover parity: PARITY_EN=1, PARITY_ODD=0, data 0x2D -> parity bit 0, 36-cycle frame; PARITY_ODD=1 -> parity bit 1.
REQ-031 SHALL cover back-to-back: three words 0x01,0x3F,0x15 pushed through the latch FIFO -> three contiguous frames, no idle cycle between stop and next start, fifo_pop low while hold_valid=1.
REQ-032 SHALL cover backpressure: fifo_write asserted while fifo_pop=0 -> word not consumed, FIFO retains it, later transmitted in order.
REQ-033 SHALL cover reset mid-frame: reset_n low during DATA bit 3 -> tx=1 and busy=0 within the same cycle, and the next word after release transmits correctly.
REQ-034 SHALL cover CLKS_PER_BIT=1: data 0x2A -> frame of 8 cycles, bits 0,0,1,0,1,0,1,1.
